configurable_logic: RTL and testbench

- Selectable two-operand bitwise logic unit; a 3-bit select line picks one of eight Boolean functions of operands A and B.
- Primary result Y is purely combinational, for use in datapath glue logic.
- Also provides a registered copy of the result with a valid flag, for pipelined consumers.
- Sits as a leaf block under control/datapath logic that drives SEL from a decoded opcode.

---
 rtl/configurable_logic_pkg.sv | 29 ++
 rtl/configurable_logic.sv | 39 +++
 tb/tb_configurable_logic.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/configurable_logic_pkg.sv
// configurable_logic_pkg: function select codes and the per-bit operator they choose.
package configurable_logic_pkg;
   typedef enum logic [2:0] {
      SEL_AND  = 3'd0,
      SEL_OR   = 3'd1,
      SEL_XOR  = 3'd2,
      SEL_NAND = 3'd3,
      SEL_NOR  = 3'd4,
      SEL_XNOR = 3'd5,
      SEL_NOTA = 3'd6,
      SEL_NOTB = 3'd7
   } sel_e;
   function automatic logic apply_op(sel_e sel, logic a, logic b);
      logic r;
      r = 1'b0;
      case (sel)
         SEL_AND:  r = a & b;
         SEL_OR:   r = a | b;
         SEL_XOR:  r = a ^ b;
         SEL_NAND: r = ~(a & b);
         SEL_NOR:  r = ~(a | b);
         SEL_XNOR: r = ~(a ^ b);
         SEL_NOTA: r = ~a;
         SEL_NOTB: r = ~b;
         default:  r = 1'bx;
      endcase
      return r;
   endfunction
endpackage

// File: rtl/configurable_logic.sv
// configurable_logic: selectable bitwise logic unit with combinational result and a registered copy.
module configurable_logic
   import configurable_logic_pkg::*;
#(
   parameter int WIDTH = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic [2:0]       SEL,
   input  logic             EN,
   output logic [WIDTH-1:0] Y,
   output logic [WIDTH-1:0] Y_Q,
   output logic             Y_Q_VALID
);
   logic [WIDTH-1:0] y_q, y_d;
   logic             valid_q, valid_d;
   always_comb begin
      Y = '0;
      for (int i = 0; i < WIDTH; i++) Y[i] = apply_op(sel_e'(SEL), A[i], B[i]);
   end
   // Valid is sticky: once anything is captured it stays set until reset.
   always_comb begin
      y_d     = EN ? Y : y_q;
      valid_d = valid_q | EN;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         y_q     <= '0;
         valid_q <= 1'b0;
      end else begin
         y_q     <= y_d;
         valid_q <= valid_d;
      end
   end
   assign Y_Q       = y_q;
   assign Y_Q_VALID = valid_q;
endmodule

// File: tb/tb_configurable_logic.sv
// tb_configurable_logic: truth-table reference model against 1-bit and 8-bit instances.
module tb_configurable_logic;
   logic       clk = 1'b0;
   logic       rst, en;
   logic [7:0] a, b, y, y_q;
   logic [2:0] sel;
   logic       y_q_valid;
   logic       c1, r1, en1, a1, b1, y1, yq1, v1;
   logic [2:0] sel1;
   int         n_checks = 0, n_fail = 0;
   logic [3:0] tt [8];
   logic [7:0] exp_q;
   logic       exp_v;
   always #5 clk = ~clk;
   configurable_logic #(.WIDTH(8)) dut8 (
      .clk(clk), .rst(rst), .A(a), .B(b), .SEL(sel), .EN(en),
      .Y(y), .Y_Q(y_q), .Y_Q_VALID(y_q_valid)
   );
   configurable_logic #(.WIDTH(1)) dut1 (
      .clk(c1), .rst(r1), .A(a1), .B(b1), .SEL(sel1), .EN(en1),
      .Y(y1), .Y_Q(yq1), .Y_Q_VALID(v1)
   );
   function automatic logic [7:0] model(logic [2:0] s, logic [7:0] x, logic [7:0] z);
      logic [7:0] r;
      logic [3:0] t;
      t = tt[s];
      for (int i = 0; i < 8; i++) r[i] = t[{x[i], z[i]}];
      return r;
   endfunction
   task automatic tick();
      @(posedge clk);
      #1;
      if (rst) begin exp_q = '0; exp_v = 1'b0; end
      else if (en) begin exp_q = model(sel, a, b); exp_v = 1'b1; end
   endtask
   task automatic test_sweep();
      logic [7:0] want;
      want = 8'b1000_1110;
      a1 = 1'b1; b1 = 1'b0;
      for (int s = 0; s < 8; s++) begin
         sel1 = 3'(s);
         #5;
         n_checks++;
         if (y1 !== want[s]) begin
            n_fail++;
            $display("FAIL sweep sel=%0d got=%b want=%b", s, y1, want[s]);
         end
      end
   endtask
   task automatic test_exhaustive();
      logic [7:0] m;
      for (int k = 0; k < 32; k++) begin
         {sel1, a1, b1} = 5'(k);
         #1;
         m = model(sel1, {7'd0, a1}, {7'd0, b1});
         n_checks++;
         if (y1 !== m[0]) begin
            n_fail++;
            $display("FAIL exhaustive sel=%0d a=%b b=%b got=%b want=%b", sel1, a1, b1, y1, m[0]);
         end
      end
   endtask
   task automatic test_wide();
      logic [2:0] s_list [6];
      logic [7:0] w_list [6];
      s_list = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd6, 3'd7};
      w_list = '{8'hC0, 8'hFC, 8'h3C, 8'h3F, 8'h0F, 8'h33};
      a = 8'hF0; b = 8'hCC; en = 1'b0; rst = 1'b0;
      for (int i = 0; i < 6; i++) begin
         sel = s_list[i];
         #1;
         n_checks++;
         if (y !== w_list[i]) begin
            n_fail++;
            $display("FAIL wide sel=%0d got=%h want=%h", sel, y, w_list[i]);
         end
      end
   endtask
   task automatic test_reset();
      rst = 1'b1;
      tick();
      tick();
      n_checks++;
      if (y_q !== 8'h00 || y_q_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL reset y_q=%h valid=%b want 00/0", y_q, y_q_valid);
      end
   endtask
   task automatic test_capture();
      rst = 1'b0; en = 1'b1; a = 8'h01; b = 8'h00; sel = 3'b001;
      tick();
      n_checks++;
      if (y_q !== 8'h01 || y_q_valid !== 1'b1) begin
         n_fail++;
         $display("FAIL capture y_q=%h valid=%b want 01/1", y_q, y_q_valid);
      end
   endtask
   task automatic test_hold();
      en = 1'b0; sel = 3'b000;
      #1;
      n_checks++;
      if (y !== 8'h00) begin
         n_fail++;
         $display("FAIL hold_comb y=%h want 00", y);
      end
      for (int i = 0; i < 3; i++) begin
         tick();
         n_checks++;
         if (y_q !== 8'h01 || y_q_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL hold cycle=%0d y_q=%h valid=%b want 01/1", i, y_q, y_q_valid);
         end
      end
      en = 1'b1;
      tick();
      n_checks++;
      if (y_q !== 8'h00 || y_q_valid !== 1'b1) begin
         n_fail++;
         $display("FAIL hold_release y_q=%h valid=%b want 00/1", y_q, y_q_valid);
      end
   endtask
   task automatic test_reset_priority();
      a = 8'h5A; b = 8'h0F; sel = 3'b010; en = 1'b1;
      tick();
      rst = 1'b1;
      tick();
      n_checks++;
      if (y_q !== 8'h00 || y_q_valid !== 1'b0 || y !== 8'h55) begin
         n_fail++;
         $display("FAIL reset_priority y_q=%h valid=%b y=%h want 00/0/55", y_q, y_q_valid, y);
      end
      rst = 1'b0;
   endtask
   task automatic test_random();
      for (int i = 0; i < 300; i++) begin
         a   = 8'($urandom);
         b   = 8'($urandom);
         sel = 3'($urandom_range(7));
         en  = ($urandom_range(3) != 0);
         rst = ($urandom_range(19) == 0);
         #1;
         n_checks++;
         if (y !== model(sel, a, b)) begin
            n_fail++;
            $display("FAIL random_comb i=%0d y=%h want=%h", i, y, model(sel, a, b));
         end
         tick();
         n_checks++;
         if (y_q !== exp_q || y_q_valid !== exp_v) begin
            n_fail++;
            $display("FAIL random_reg i=%0d y_q=%h valid=%b want=%h/%b", i, y_q, y_q_valid, exp_q, exp_v);
         end
      end
   endtask
   initial begin
      tt = '{4'b1000, 4'b1110, 4'b0110, 4'b0111, 4'b0001, 4'b1001, 4'b0011, 4'b0101};
      exp_q = '0; exp_v = 1'b0;
      rst = 1'b1; en = 1'b0; a = '0; b = '0; sel = '0;
      a1 = 1'b0; b1 = 1'b0; sel1 = '0;
      #2;
      test_sweep();
      test_exhaustive();
      test_wide();
      test_reset();
      test_capture();
      test_hold();
      test_reset_priority();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
